jt6295_hdr_fetch: RTL and testbench

Phrase-header fetcher for the JT6295 ADPCM core. It queues per-channel play requests, reads each requested phrase's 6-byte header from the sample ROM through one slot of the ROM arbiter, and delivers the 18-bit start and end addresses to the channel sequencer. It sits directly upstream of the ROM arbiter's slot 0 (cs/addr out, dout/ok in) and downstream of the command decoder.

---
 rtl/jt6295_hdr_fetch_if.sv | 28 ++
 rtl/jt6295_hdr_fetch.sv | 140 ++++++++++++++
 tb/tb_jt6295_hdr_fetch.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jt6295_hdr_fetch_if.sv
`timescale 1ns/1ps
// Signal bundle for the JT6295 phrase-header fetcher: play requests from the
// command decoder, ROM arbiter slot 0, and header delivery to the sequencer.
interface jt6295_hdr_fetch_if;
    logic        start;
    logic [1:0]  start_ch;
    logic [6:0]  start_phrase;
    logic        busy;
    logic        rom_cs;
    logic [17:0] rom_addr;
    logic [7:0]  rom_data;
    logic        rom_ok;
    logic        hdr_valid;
    logic [1:0]  hdr_ch;
    logic [17:0] hdr_start;
    logic [17:0] hdr_end;
    logic        hdr_err;

    modport master (
        input  start, start_ch, start_phrase, rom_data, rom_ok,
        output busy, rom_cs, rom_addr, hdr_valid, hdr_ch, hdr_start, hdr_end, hdr_err
    );

    modport slave (
        output start, start_ch, start_phrase, rom_data, rom_ok,
        input  busy, rom_cs, rom_addr, hdr_valid, hdr_ch, hdr_start, hdr_end, hdr_err
    );
endinterface

// File: rtl/jt6295_hdr_fetch.sv
`timescale 1ns/1ps
// Queues per-channel play requests and reads each phrase's 6-byte header from
// ROM slot 0, delivering 18-bit start/end addresses to the channel sequencer.
module jt6295_hdr_fetch (
    input  logic               rst,
    input  logic               clk,
    jt6295_hdr_fetch_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETUP, WAIT, DONE} state_t;

    state_t      state;
    state_t      next_state;

    logic [3:0]  pending;
    logic [6:0]  phrase_q [0:3];
    logic [1:0]  pick_ch;
    logic        pick;
    logic [3:0]  set_mask;
    logic [3:0]  clr_mask;
    logic [1:0]  ch_q;
    logic        zero_q;
    logic [2:0]  cnt;
    logic [17:0] addr_q;
    logic [17:0] start_acc;
    logic [9:0]  end_acc;
    logic [17:0] end_w;
    logic [1:0]  hdr_ch_q;
    logic [17:0] hdr_start_q;
    logic [17:0] hdr_end_q;
    logic        hdr_err_q;
    logic        busy_w;
    logic        rom_cs_w;
    logic        hdr_valid_w;

    always_comb begin
        pick_ch = 2'd3;
        if (pending[0])      pick_ch = 2'd0;
        else if (pending[1]) pick_ch = 2'd1;
        else if (pending[2]) pick_ch = 2'd2;
    end

    // A start landing on the channel being picked re-arms it: set beats clear.
    assign pick     = (state == IDLE) && (pending != 4'd0);
    assign set_mask = bus.start ? (4'b0001 << bus.start_ch) : 4'b0000;
    assign clr_mask = pick ? (4'b0001 << pick_ch) : 4'b0000;
    assign end_w    = {end_acc, bus.rom_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // A phrase-0 request still spends one SETUP cycle, with the slot request
    // suppressed, so its error delivery lands two edges after the start.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pick) next_state = SETUP;
            SETUP:   next_state = zero_q ? DONE : WAIT;
            WAIT:    if (bus.rom_ok) next_state = (cnt == 3'd5) ? DONE : SETUP;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy_w      = (state != IDLE);
        rom_cs_w    = ((state == SETUP) || (state == WAIT)) && !zero_q;
        hdr_valid_w = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending     <= 4'd0;
            for (int i = 0; i < 4; i++) phrase_q[i] <= 7'd0;
            ch_q        <= 2'd0;
            zero_q      <= 1'b0;
            cnt         <= 3'd0;
            addr_q      <= 18'd0;
            start_acc   <= 18'd0;
            end_acc     <= 10'd0;
            hdr_ch_q    <= 2'd0;
            hdr_start_q <= 18'd0;
            hdr_end_q   <= 18'd0;
            hdr_err_q   <= 1'b0;
        end else begin
            pending <= (pending & ~clr_mask) | set_mask;
            if (bus.start) phrase_q[bus.start_ch] <= bus.start_phrase;
            case (state)
                IDLE: begin
                    if (pick) begin
                        ch_q   <= pick_ch;
                        zero_q <= (phrase_q[pick_ch] == 7'd0);
                        cnt    <= 3'd0;
                        addr_q <= {8'd0, phrase_q[pick_ch], 3'b000};
                    end
                end
                SETUP: begin
                    if (zero_q) begin
                        hdr_ch_q    <= ch_q;
                        hdr_start_q <= 18'd0;
                        hdr_end_q   <= 18'd0;
                        hdr_err_q   <= 1'b1;
                    end
                end
                WAIT: begin
                    if (bus.rom_ok) begin
                        case (cnt)
                            3'd0:    start_acc[17:16] <= bus.rom_data[1:0];
                            3'd1:    start_acc[15:8]  <= bus.rom_data;
                            3'd2:    start_acc[7:0]   <= bus.rom_data;
                            3'd3:    end_acc[9:8]     <= bus.rom_data[1:0];
                            3'd4:    end_acc[7:0]     <= bus.rom_data;
                            default: ;
                        endcase
                        if (cnt == 3'd5) begin
                            hdr_ch_q    <= ch_q;
                            hdr_start_q <= start_acc;
                            hdr_end_q   <= end_w;
                            hdr_err_q   <= (end_w < start_acc);
                        end else begin
                            cnt    <= cnt + 3'd1;
                            addr_q <= addr_q + 18'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = busy_w;
    assign bus.rom_cs    = rom_cs_w;
    assign bus.rom_addr  = addr_q;
    assign bus.hdr_valid = hdr_valid_w;
    assign bus.hdr_ch    = hdr_ch_q;
    assign bus.hdr_start = hdr_start_q;
    assign bus.hdr_end   = hdr_end_q;
    assign bus.hdr_err   = hdr_err_q;
endmodule

// File: tb/tb_jt6295_hdr_fetch.sv
`timescale 1ns/1ps
// Directed bench for jt6295_hdr_fetch: byte-wide ROM model whose ok can be
// throttled, plus monitors recording delivered headers and fetched addresses.
module tb_jt6295_hdr_fetch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    jt6295_hdr_fetch_if bus ();

    jt6295_hdr_fetch dut (
        .rst (rst),
        .clk (clk),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]  rom_mem [0:1023];
    logic        stall_mode = 1'b0;
    logic [17:0] last_addr  = '0;
    logic [3:0]  age        = '0;

    assign bus.rom_data = (bus.rom_addr < 18'd1024) ? rom_mem[bus.rom_addr[9:0]] : 8'h00;
    assign bus.rom_ok   = stall_mode ? (bus.rom_cs && (bus.rom_addr == last_addr) && (age >= 4'd3)) : 1'b1;

    // In stall mode ok rises only after the address has been seen for 3 edges.
    always @(posedge clk) begin
        if (bus.rom_addr != last_addr) begin
            last_addr <= bus.rom_addr;
            age       <= '0;
        end else if (age != 4'hF) begin
            age <= age + 4'd1;
        end
    end

    typedef struct packed {
        logic [1:0]  ch;
        logic [17:0] s;
        logic [17:0] e;
        logic        err;
    } hdr_t;

    hdr_t        dq [$];
    logic [17:0] aq [$];
    logic        prev_cs   = 1'b0;
    logic [17:0] prev_addr = '0;

    always @(negedge clk) begin
        if (bus.hdr_valid) dq.push_back({bus.hdr_ch, bus.hdr_start, bus.hdr_end, bus.hdr_err});
        if (bus.rom_cs && (!prev_cs || bus.rom_addr != prev_addr)) aq.push_back(bus.rom_addr);
        prev_cs   <= bus.rom_cs;
        prev_addr <= bus.rom_addr;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic hdr_t mk(input logic [1:0] ch, input logic [17:0] s, input logic [17:0] e, input logic err);
        mk = {ch, s, e, err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_start(input logic [1:0] ch, input logic [6:0] ph);
        bus.start        = 1'b1;
        bus.start_ch     = ch;
        bus.start_phrase = ph;
        tick();
        bus.start        = 1'b0;
    endtask

    task automatic load_hdr(input int ph, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
        rom_mem[ph*8+0] = b0; rom_mem[ph*8+1] = b1; rom_mem[ph*8+2] = b2;
        rom_mem[ph*8+3] = b3; rom_mem[ph*8+4] = b4; rom_mem[ph*8+5] = b5;
    endtask

    task automatic wait_deliveries(input int n, input int budget);
        int k = 0;
        while (dq.size() < n && k < budget) begin
            tick();
            k++;
        end
        tests++;
        if (dq.size() < n) begin
            fails++;
            $display("[TB] FAIL wait_deliveries: got %0d headers, expected %0d within %0d cycles", dq.size(), n, budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        tests++;
        if ({bus.busy, bus.rom_cs, bus.rom_addr, bus.hdr_valid, bus.hdr_ch, bus.hdr_start, bus.hdr_end, bus.hdr_err} !== 60'd0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got busy=%b cs=%b addr=%h valid=%b ch=%0d s=%h e=%h err=%b, expected all 0",
                     bus.busy, bus.rom_cs, bus.rom_addr, bus.hdr_valid, bus.hdr_ch, bus.hdr_start, bus.hdr_end, bus.hdr_err);
        end
        rst = 1'b0;
        repeat (3) tick();
        tests++;
        if (bus.busy !== 1'b0 || dq.size() != 0) begin
            fails++;
            $display("[TB] FAIL reset_release_idle: got busy=%b headers=%0d, expected busy=0 headers=0", bus.busy, dq.size());
        end
    endtask

    task automatic test_basic();
        int   bad = 0;
        hdr_t got;
        aq.delete(); dq.delete();
        issue_start(2'd0, 7'd1);
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (bus.rom_cs !== 1'b1 || bus.rom_addr !== 18'(8 + (k - 1) / 2) || bus.hdr_valid !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("[TB] FAIL basic_addr_seq: got %0d bad cycles, expected 0", bad);
        end
        tick();
        tests++;
        if (bus.hdr_valid !== 1'b1 || bus.rom_cs !== 1'b0 || bus.busy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL basic_valid_edge13: got valid=%b cs=%b busy=%b, expected 1 0 1", bus.hdr_valid, bus.rom_cs, bus.busy);
        end
        got = {bus.hdr_ch, bus.hdr_start, bus.hdr_end, bus.hdr_err};
        tests++;
        if (got !== mk(2'd0, 18'h31234, 18'h35678, 1'b0)) begin
            fails++;
            $display("[TB] FAIL basic_header: got %h, expected %h", got, mk(2'd0, 18'h31234, 18'h35678, 1'b0));
        end
        tick();
        got = {bus.hdr_ch, bus.hdr_start, bus.hdr_end, bus.hdr_err};
        tests++;
        if (bus.hdr_valid !== 1'b0 || bus.busy !== 1'b0 || got !== mk(2'd0, 18'h31234, 18'h35678, 1'b0)) begin
            fails++;
            $display("[TB] FAIL basic_hold_edge14: got valid=%b busy=%b hdr=%h, expected 0 0 %h",
                     bus.hdr_valid, bus.busy, got, mk(2'd0, 18'h31234, 18'h35678, 1'b0));
        end
        bad = (aq.size() == 6) ? 0 : 1;
        for (int i = 0; i < 6 && bad == 0; i++) if (aq[i] !== 18'(8 + i)) bad = 1;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("[TB] FAIL basic_addr_list: got %0d addresses, expected 8..13", aq.size());
        end
    endtask

    task automatic test_phrase_zero();
        aq.delete(); dq.delete();
        issue_start(2'd1, 7'd0);
        tick();
        tests++;
        if (bus.hdr_valid !== 1'b0 || bus.busy !== 1'b1 || bus.rom_cs !== 1'b0) begin
            fails++;
            $display("[TB] FAIL zero_edge1: got valid=%b busy=%b cs=%b, expected 0 1 0", bus.hdr_valid, bus.busy, bus.rom_cs);
        end
        tick();
        tests++;
        if ({bus.hdr_valid, bus.hdr_ch, bus.hdr_start, bus.hdr_end, bus.hdr_err} !== {1'b1, mk(2'd1, 18'd0, 18'd0, 1'b1)}) begin
            fails++;
            $display("[TB] FAIL zero_edge2: got valid=%b ch=%0d s=%h e=%h err=%b, expected 1 1 0 0 1",
                     bus.hdr_valid, bus.hdr_ch, bus.hdr_start, bus.hdr_end, bus.hdr_err);
        end
        tick();
        tests++;
        if (bus.hdr_valid !== 1'b0 || bus.busy !== 1'b0 || aq.size() != 0) begin
            fails++;
            $display("[TB] FAIL zero_no_rom: got valid=%b busy=%b rom_fetches=%0d, expected 0 0 0", bus.hdr_valid, bus.busy, aq.size());
        end
    endtask

    task automatic test_order();
        logic [17:0] exp_a [$];
        int bad = 0;
        aq.delete(); dq.delete();
        issue_start(2'd1, 7'd2);
        repeat (2) tick();
        issue_start(2'd2, 7'd3);
        issue_start(2'd0, 7'd4);
        wait_deliveries(3, 100);
        repeat (20) tick();
        tests++;
        if (dq.size() != 3 || dq[0] !== mk(2'd1, 18'h00100, 18'h00200, 1'b0)
            || dq[1] !== mk(2'd0, 18'h20010, 18'h3FFFF, 1'b0) || dq[2] !== mk(2'd2, 18'h1ABCD, 18'h21122, 1'b0)) begin
            fails++;
            $display("[TB] FAIL order_headers: got %0d headers first=%h, expected ch1,ch0,ch2 (%h,%h,%h)", dq.size(),
                     (dq.size() > 0) ? dq[0] : hdr_t'(0), mk(2'd1, 18'h00100, 18'h00200, 1'b0),
                     mk(2'd0, 18'h20010, 18'h3FFFF, 1'b0), mk(2'd2, 18'h1ABCD, 18'h21122, 1'b0));
        end
        for (int i = 0; i < 6; i++) exp_a.push_back(18'(16 + i));
        for (int i = 0; i < 6; i++) exp_a.push_back(18'(32 + i));
        for (int i = 0; i < 6; i++) exp_a.push_back(18'(24 + i));
        bad = (aq.size() == 18) ? 0 : 1;
        for (int i = 0; i < 18 && bad == 0; i++) if (aq[i] !== exp_a[i]) bad = 1;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("[TB] FAIL order_addr_list: got %0d addresses, expected 0x10-15,0x20-25,0x18-1D", aq.size());
        end
    endtask

    task automatic test_overwrite();
        logic [17:0] exp_a [$];
        int bad = 0;
        aq.delete(); dq.delete();
        issue_start(2'd0, 7'd1);
        tick();
        issue_start(2'd3, 7'd5);
        issue_start(2'd3, 7'd9);
        wait_deliveries(2, 100);
        repeat (20) tick();
        tests++;
        if (dq.size() != 2 || dq[1] !== mk(2'd3, 18'h00005, 18'h00006, 1'b0)) begin
            fails++;
            $display("[TB] FAIL overwrite_headers: got %0d headers last=%h, expected 2 last=%h", dq.size(),
                     (dq.size() > 1) ? dq[1] : hdr_t'(0), mk(2'd3, 18'h00005, 18'h00006, 1'b0));
        end
        for (int i = 0; i < 6; i++) exp_a.push_back(18'(8 + i));
        for (int i = 0; i < 6; i++) exp_a.push_back(18'(72 + i));
        bad = (aq.size() == 12) ? 0 : 1;
        for (int i = 0; i < 12 && bad == 0; i++) if (aq[i] !== exp_a[i]) bad = 1;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("[TB] FAIL overwrite_addr_list: got %0d addresses, expected 8-13 then 0x48-4D", aq.size());
        end
    endtask

    task automatic test_same_cycle();
        aq.delete(); dq.delete();
        issue_start(2'd2, 7'd2);
        issue_start(2'd2, 7'd3);
        wait_deliveries(2, 100);
        repeat (20) tick();
        tests++;
        if (dq.size() != 2 || dq[0] !== mk(2'd2, 18'h00100, 18'h00200, 1'b0) || dq[1] !== mk(2'd2, 18'h1ABCD, 18'h21122, 1'b0)) begin
            fails++;
            $display("[TB] FAIL same_cycle_headers: got %0d headers first=%h, expected %h then %h", dq.size(),
                     (dq.size() > 0) ? dq[0] : hdr_t'(0), mk(2'd2, 18'h00100, 18'h00200, 1'b0), mk(2'd2, 18'h1ABCD, 18'h21122, 1'b0));
        end
    endtask

    task automatic test_hdr_err();
        aq.delete(); dq.delete();
        issue_start(2'd0, 7'd6);
        issue_start(2'd1, 7'd8);
        wait_deliveries(2, 100);
        tests++;
        if (dq.size() < 1 || dq[0] !== mk(2'd0, 18'h00200, 18'h00100, 1'b1)) begin
            fails++;
            $display("[TB] FAIL err_end_below_start: got %h, expected %h", (dq.size() > 0) ? dq[0] : hdr_t'(0),
                     mk(2'd0, 18'h00200, 18'h00100, 1'b1));
        end
        tests++;
        if (dq.size() < 2 || dq[1] !== mk(2'd1, 18'h00077, 18'h00077, 1'b0)) begin
            fails++;
            $display("[TB] FAIL err_equal_ok: got %h, expected %h", (dq.size() > 1) ? dq[1] : hdr_t'(0),
                     mk(2'd1, 18'h00077, 18'h00077, 1'b0));
        end
        repeat (5) tick();
    endtask

    task automatic test_stall();
        int   bad = 0;
        hdr_t got;
        aq.delete(); dq.delete();
        stall_mode = 1'b1;
        issue_start(2'd0, 7'd7);
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (bus.rom_cs !== 1'b1 || bus.rom_addr !== 18'(56 + (k - 1) / 5) || bus.hdr_valid !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("[TB] FAIL stall_addr_stable: got %0d bad cycles, expected 0", bad);
        end
        tick();
        got = {bus.hdr_ch, bus.hdr_start, bus.hdr_end, bus.hdr_err};
        tests++;
        if (bus.hdr_valid !== 1'b1 || got !== mk(2'd0, 18'h23456, 18'h30001, 1'b0)) begin
            fails++;
            $display("[TB] FAIL stall_valid_edge31: got valid=%b hdr=%h, expected 1 %h", bus.hdr_valid, got,
                     mk(2'd0, 18'h23456, 18'h30001, 1'b0));
        end
        tick();
        stall_mode = 1'b0;
    endtask

    task automatic test_reset_mid();
        aq.delete(); dq.delete();
        issue_start(2'd0, 7'd1);
        issue_start(2'd2, 7'd3);
        repeat (7) tick();
        tests++;
        if (bus.rom_cs !== 1'b1 || bus.rom_addr !== 18'd11) begin
            fails++;
            $display("[TB] FAIL reset_mid_setup: got cs=%b addr=%h, expected 1 00b", bus.rom_cs, bus.rom_addr);
        end
        rst = 1'b1;
        #1;
        tests++;
        if ({bus.busy, bus.rom_cs, bus.rom_addr, bus.hdr_valid, bus.hdr_ch, bus.hdr_start, bus.hdr_end, bus.hdr_err} !== 60'd0) begin
            fails++;
            $display("[TB] FAIL reset_mid_async: got busy=%b cs=%b addr=%h valid=%b ch=%0d s=%h e=%h err=%b, expected all 0",
                     bus.busy, bus.rom_cs, bus.rom_addr, bus.hdr_valid, bus.hdr_ch, bus.hdr_start, bus.hdr_end, bus.hdr_err);
        end
        tick();
        rst = 1'b0;
        repeat (30) tick();
        tests++;
        if (dq.size() != 0 || aq.size() != 4 || bus.busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_mid_quiet: got headers=%0d fetches=%0d busy=%b, expected 0 4 0", dq.size(), aq.size(), bus.busy);
        end
        issue_start(2'd1, 7'd2);
        wait_deliveries(1, 100);
        tests++;
        if (dq.size() < 1 || dq[0] !== mk(2'd1, 18'h00100, 18'h00200, 1'b0)) begin
            fails++;
            $display("[TB] FAIL reset_mid_restart: got %h, expected %h", (dq.size() > 0) ? dq[0] : hdr_t'(0),
                     mk(2'd1, 18'h00100, 18'h00200, 1'b0));
        end
    endtask

    initial begin
        bus.start        = 1'b0;
        bus.start_ch     = 2'd0;
        bus.start_phrase = 7'd0;
        for (int i = 0; i < 1024; i++) rom_mem[i] = 8'h00;
        load_hdr(1, 8'h03, 8'h12, 8'h34, 8'h03, 8'h56, 8'h78);
        load_hdr(2, 8'h00, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00);
        load_hdr(3, 8'h01, 8'hAB, 8'hCD, 8'h02, 8'h11, 8'h22);
        load_hdr(4, 8'hFE, 8'h00, 8'h10, 8'hFF, 8'hFF, 8'hFF);
        load_hdr(5, 8'h00, 8'h00, 8'hAA, 8'h00, 8'h00, 8'hBB);
        load_hdr(6, 8'h00, 8'h02, 8'h00, 8'h00, 8'h01, 8'h00);
        load_hdr(7, 8'h02, 8'h34, 8'h56, 8'h03, 8'h00, 8'h01);
        load_hdr(8, 8'h00, 8'h00, 8'h77, 8'h00, 8'h00, 8'h77);
        load_hdr(9, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h06);

        test_reset();
        test_basic();
        test_phrase_zero();
        test_order();
        test_overwrite();
        test_same_cycle();
        test_hdr_err();
        test_stall();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
